// File: rtl/fifo_buffer_param.sv
// Parametrised single-clock FIFO with registered or first-word-fall-through read,
// occupancy count, programmable almost flags and sticky overflow/underflow flags.
module fifo_buffer_param #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2,
  parameter int FWFT       = 0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    EN,
  input  logic                    WR,
  input  logic                    RD,
  input  logic [DATA_WIDTH-1:0]   dataIn,
  input  logic                    clr_err,
  output logic [DATA_WIDTH-1:0]   dataOut,
  output logic                    valid,
  output logic                    EMPTY,
  output logic                    FULL,
  output logic                    ALMOST_EMPTY,
  output logic                    ALMOST_FULL,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    OVERFLOW,
  output logic                    UNDERFLOW
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_ovf;
  logic                  r_udf;

  logic w_empty;
  logic w_full;
  logic w_rd_acc;
  logic w_wr_acc;
  logic w_ovf_set;
  logic w_udf_set;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));

  // Handshake: WR and RD are single-cycle requests qualified by EN. A read is
  // accepted when the FIFO holds data; a write is accepted when there is room or
  // a read is accepted in the same cycle (so a full FIFO streams through).
  // A request that is not accepted is dropped and latches the matching sticky
  // error flag; nothing is retried.
  assign w_rd_acc  = EN & RD & ~w_empty;
  assign w_wr_acc  = EN & WR & (~w_full | w_rd_acc);
  assign w_ovf_set = EN & WR & ~w_wr_acc;
  assign w_udf_set = EN & RD & w_empty;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_wr_acc && !w_rd_acc)      r_count <= r_count + CW'(1);
      else if (w_rd_acc && !w_wr_acc) r_count <= r_count - CW'(1);
      // A new error in the clearing cycle wins over the clear.
      if (EN && clr_err) begin
        r_ovf <= w_ovf_set;
        r_udf <= w_udf_set;
      end else begin
        r_ovf <= r_ovf | w_ovf_set;
        r_udf <= r_udf | w_udf_set;
      end
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clock) begin
    if (w_wr_acc) r_mem[r_wr_ptr] <= dataIn;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is shown combinationally; forced to zero while empty so reset
      // drives dataOut to 0 even though the array is not cleared.
      assign dataOut = w_empty ? '0 : r_mem[r_rd_ptr];
      assign valid   = ~w_empty;
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] r_dout;
      logic                  r_valid;

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          r_dout  <= '0;
          r_valid <= 1'b0;
        end else begin
          r_valid <= w_rd_acc;
          if (w_rd_acc) r_dout <= r_mem[r_rd_ptr];
        end
      end

      assign dataOut = r_dout;
      assign valid   = r_valid;
    end
  endgenerate

  assign count        = r_count;
  assign EMPTY        = w_empty;
  assign FULL         = w_full;
  assign ALMOST_EMPTY = (r_count <= CW'(AE_LEVEL));
  assign ALMOST_FULL  = (r_count >= CW'(AF_LEVEL));
  assign OVERFLOW     = r_ovf;
  assign UNDERFLOW    = r_udf;

endmodule

// File: tb/tb_fifo_buffer_param.sv
// Bench for fifo_buffer_param: table of directed vectors on a registered-read
// instance plus hand sequences for FWFT wrap-around and asynchronous reset.
module tb_fifo_buffer_param;

  logic       clock = 1'b0;
  logic       reset;

  // registered-read instance
  logic       en, wr, rd, clr;
  logic [7:0] din, dout;
  logic       vld, empty, full, aempty, afull, ovf, udf;
  logic [4:0] cnt;

  // first-word-fall-through instance
  logic       f_en, f_wr, f_rd, f_clr;
  logic [7:0] f_din, f_dout;
  logic       f_vld, f_empty, f_full, f_aempty, f_afull, f_ovf, f_udf;
  logic [4:0] f_cnt;

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] exp_q[$];

  typedef struct packed {
    logic       en, wr, rd, clr;
    logic [7:0] din;
    logic [4:0] cnt;
    logic       vld;
    logic [7:0] dout;
    logic       ovf, udf;
  } vec_t;

  vec_t vecs[64];
  int   n_vec;

  fifo_buffer_param #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(0)) u_rg (
    .clock(clock), .reset(reset), .EN(en), .WR(wr), .RD(rd), .dataIn(din),
    .clr_err(clr), .dataOut(dout), .valid(vld), .EMPTY(empty), .FULL(full),
    .ALMOST_EMPTY(aempty), .ALMOST_FULL(afull), .count(cnt),
    .OVERFLOW(ovf), .UNDERFLOW(udf)
  );

  fifo_buffer_param #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(1)) u_fw (
    .clock(clock), .reset(reset), .EN(f_en), .WR(f_wr), .RD(f_rd), .dataIn(f_din),
    .clr_err(f_clr), .dataOut(f_dout), .valid(f_vld), .EMPTY(f_empty), .FULL(f_full),
    .ALMOST_EMPTY(f_aempty), .ALMOST_FULL(f_afull), .count(f_cnt),
    .OVERFLOW(f_ovf), .UNDERFLOW(f_udf)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    else
      n_pass++;
  endtask

  function automatic vec_t mk(input logic e, input logic w, input logic r, input logic c,
                              input logic [7:0] d, input int ec, input logic ev,
                              input logic [7:0] ed, input logic eo, input logic eu);
    vec_t v;
    v.en = e; v.wr = w; v.rd = r; v.clr = c; v.din = d;
    v.cnt = 5'(ec); v.vld = ev; v.dout = ed; v.ovf = eo; v.udf = eu;
    return v;
  endfunction

  task automatic add(input vec_t v);
    vecs[n_vec] = v;
    n_vec++;
  endtask

  initial begin
    en = 1'b1; wr = 1'b0; rd = 1'b0; clr = 1'b0; din = '0;
    f_en = 1'b1; f_wr = 1'b0; f_rd = 1'b0; f_clr = 1'b0; f_din = '0;
    reset = 1'b0;

    // --- vector table (registered-read instance) ---
    n_vec = 0;
    for (int i = 0; i < 16; i++)                       // fill 0x00..0x0F
      add(mk(1, 1, 0, 0, 8'(i), i + 1, 0, 8'h00, 0, 0));
    add(mk(1, 1, 0, 0, 8'hAA, 16, 0, 8'h00, 1, 0));    // rejected write on full
    add(mk(1, 0, 0, 1, 8'h00, 16, 0, 8'h00, 0, 0));    // clear overflow
    add(mk(1, 1, 1, 0, 8'h77, 16, 1, 8'h00, 0, 0));    // WR&RD on full
    for (int i = 1; i < 16; i++)                       // drain 0x01..0x0F
      add(mk(1, 0, 1, 0, 8'h00, 16 - i, 1, 8'(i), 0, 0));
    add(mk(1, 0, 1, 0, 8'h00, 0, 1, 8'h77, 0, 0));     // last word is 0x77
    add(mk(1, 0, 0, 0, 8'h00, 0, 0, 8'h77, 0, 0));     // idle: valid drops, data holds
    add(mk(1, 0, 1, 0, 8'h00, 0, 0, 8'h77, 0, 1));     // read on empty
    add(mk(1, 0, 0, 1, 8'h00, 0, 0, 8'h77, 0, 0));     // clear underflow
    add(mk(1, 1, 1, 0, 8'h55, 1, 0, 8'h77, 0, 1));     // WR&RD on empty
    add(mk(1, 0, 1, 0, 8'h00, 0, 1, 8'h55, 0, 1));     // returns 0x55
    add(mk(1, 0, 0, 1, 8'h00, 0, 0, 8'h55, 0, 0));
    add(mk(1, 1, 0, 0, 8'h11, 1, 0, 8'h55, 0, 0));
    add(mk(1, 1, 0, 0, 8'h22, 2, 0, 8'h55, 0, 0));
    add(mk(1, 0, 1, 0, 8'h00, 1, 1, 8'h11, 0, 0));
    add(mk(0, 1, 1, 1, 8'h99, 1, 0, 8'h11, 0, 0));     // EN=0 freezes
    add(mk(1, 0, 1, 0, 8'h00, 0, 1, 8'h22, 0, 0));
    add(mk(1, 0, 1, 0, 8'h00, 0, 0, 8'h22, 0, 1));
    add(mk(0, 0, 1, 1, 8'h00, 0, 0, 8'h22, 0, 1));     // clear ignored with EN=0
    add(mk(1, 0, 0, 1, 8'h00, 0, 0, 8'h22, 0, 0));

    // --- reset state ---
    #2;
    chk("rst count", 32'(cnt), 0);
    chk("rst empty", 32'(empty), 1);
    chk("rst full", 32'(full), 0);
    chk("rst aempty", 32'(aempty), 1);
    chk("rst afull", 32'(afull), 0);
    chk("rst valid", 32'(vld), 0);
    chk("rst dout", 32'(dout), 0);
    chk("rst ovf", 32'(ovf), 0);
    chk("rst udf", 32'(udf), 0);
    chk("rst f_valid", 32'(f_vld), 0);
    chk("rst f_dout", 32'(f_dout), 0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;

    for (int i = 0; i < n_vec; i++) begin
      en = vecs[i].en; wr = vecs[i].wr; rd = vecs[i].rd;
      clr = vecs[i].clr; din = vecs[i].din;
      @(posedge clock); #1;
      chk($sformatf("v%0d count", i), 32'(cnt), 32'(vecs[i].cnt));
      chk($sformatf("v%0d valid", i), 32'(vld), 32'(vecs[i].vld));
      chk($sformatf("v%0d dout", i), 32'(dout), 32'(vecs[i].dout));
      chk($sformatf("v%0d ovf", i), 32'(ovf), 32'(vecs[i].ovf));
      chk($sformatf("v%0d udf", i), 32'(udf), 32'(vecs[i].udf));
      chk($sformatf("v%0d empty", i), 32'(empty), 32'(vecs[i].cnt == 0));
      chk($sformatf("v%0d full", i), 32'(full), 32'(vecs[i].cnt == 16));
      chk($sformatf("v%0d afull", i), 32'(afull), 32'(vecs[i].cnt >= 14));
      chk($sformatf("v%0d aempty", i), 32'(aempty), 32'(vecs[i].cnt <= 2));
    end
    en = 1'b1; wr = 1'b0; rd = 1'b0; clr = 1'b0;

    // --- FWFT: prime 3 entries, then 40 write/read pairs across the wrap ---
    for (int i = 0; i < 3; i++) begin
      f_wr = 1'b1; f_din = 8'(i);
      exp_q.push_back(8'(i));
      @(posedge clock); #1;
      chk($sformatf("fw prime%0d count", i), 32'(f_cnt), 32'(exp_q.size()));
      chk($sformatf("fw prime%0d dout", i), 32'(f_dout), 32'(exp_q[0]));
      chk($sformatf("fw prime%0d valid", i), 32'(f_vld), 1);
    end
    for (int i = 0; i < 40; i++) begin
      f_wr = 1'b1; f_rd = 1'b1; f_din = 8'(8'h30 + i);
      exp_q.push_back(8'(8'h30 + i));
      void'(exp_q.pop_front());
      @(posedge clock); #1;
      chk($sformatf("fw pair%0d count", i), 32'(f_cnt), 3);
      chk($sformatf("fw pair%0d dout", i), 32'(f_dout), 32'(exp_q[0]));
      chk($sformatf("fw pair%0d valid", i), 32'(f_vld), 32'(!f_empty));
    end
    f_wr = 1'b0; f_rd = 1'b0;
    f_en = 1'b0; f_wr = 1'b1; f_rd = 1'b1; f_din = 8'hEE;   // EN=0 on FWFT
    @(posedge clock); #1;
    chk("fw en0 count", 32'(f_cnt), 3);
    chk("fw en0 dout", 32'(f_dout), 32'(exp_q[0]));
    chk("fw en0 valid", 32'(f_vld), 1);
    f_en = 1'b1; f_wr = 1'b0; f_rd = 1'b0;

    // --- reset asserted mid-burst, checked before the next edge ---
    for (int i = 0; i < 3; i++) begin
      wr = 1'b1; din = 8'(8'hC0 + i);
      f_wr = 1'b1; f_rd = 1'b1; f_din = 8'(8'hD0 + i);
      @(posedge clock); #1;
    end
    rd = 1'b1;
    @(posedge clock); #2;
    reset = 1'b0;
    #1;
    chk("mid rst count", 32'(cnt), 0);
    chk("mid rst empty", 32'(empty), 1);
    chk("mid rst valid", 32'(vld), 0);
    chk("mid rst dout", 32'(dout), 0);
    chk("mid rst f_count", 32'(f_cnt), 0);
    chk("mid rst f_valid", 32'(f_vld), 0);
    chk("mid rst f_dout", 32'(f_dout), 0);
    wr = 1'b0; rd = 1'b0; f_wr = 1'b0; f_rd = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    wr = 1'b1; din = 8'h3C;
    @(posedge clock); #1;
    wr = 1'b0; rd = 1'b1;
    @(posedge clock); #1;
    chk("post rst dout", 32'(dout), 32'h3C);
    chk("post rst valid", 32'(vld), 1);
    chk("post rst count", 32'(cnt), 0);
    rd = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
